// File: rtl/wait_fare.sv
// Waiting-time surcharge for the taxi fare totaliser: counts stationary seconds while hired
// and accumulates a saturating packed-BCD fare plus BCD waiting minutes.
module wait_fare #(
    parameter int unsigned WAIT_UNIT_S   = 300,
    parameter logic [15:0] WAIT_RATE_BCD = 16'h0010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trip_active,
    input  logic        moving,
    input  logic        tick_1s,
    output logic [15:0] wait_fare_bcd,
    output logic [7:0]  wait_min_bcd,
    output logic        waiting,
    output logic        wait_sat
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVING,
        ST_WAITING
    } state_t;

    localparam logic [11:0] UNIT_LAST = 12'(WAIT_UNIT_S - 1);
    localparam logic [5:0]  SEC_LAST  = 6'd59;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_trip_q;
    logic [11:0] r_unit_cnt;
    logic [5:0]  r_sec_cnt;
    logic [15:0] r_fare;
    logic [7:0]  r_min;
    logic        r_waiting;
    logic        r_sat;

    logic        w_trip_start;
    logic        w_count;
    logic [16:0] w_add;

    // Four-digit BCD adder; bit 16 is the carry out of the thousands digit.
    function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] sum;
        logic        carry;
        logic [4:0]  s;
        sum   = '0;
        carry = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, carry};
            if (s > 5'd9) begin
                sum[4*i +: 4] = 4'(s - 5'd10);
                carry         = 1'b1;
            end else begin
                sum[4*i +: 4] = s[3:0];
                carry         = 1'b0;
            end
        end
        return {carry, sum};
    endfunction

    function automatic logic [7:0] bcd_min_inc(input logic [7:0] m);
        logic [7:0] r;
        if (m == 8'h99) begin
            r = m;
        end else if (m[3:0] == 4'd9) begin
            r = {m[7:4] + 4'd1, 4'd0};
        end else begin
            r = {m[7:4], m[3:0] + 4'd1};
        end
        return r;
    endfunction

    assign w_trip_start = trip_active & ~r_trip_q;
    assign w_count      = (r_state == ST_WAITING) & tick_1s;
    assign w_add        = bcd_add(r_fare, WAIT_RATE_BCD);

    // NOTE: next_state gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        if (!trip_active) begin
            w_next_state = ST_IDLE;
        end else if (!moving) begin
            w_next_state = ST_WAITING;
        end else begin
            w_next_state = ST_MOVING;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_trip_q   <= 1'b0;
            r_waiting  <= 1'b0;
            r_unit_cnt <= '0;
            r_sec_cnt  <= '0;
            r_fare     <= '0;
            r_min      <= '0;
            r_sat      <= 1'b0;
        end else begin
            r_trip_q  <= trip_active;
            r_waiting <= (w_next_state == ST_WAITING);
            if (w_trip_start) begin
                // A new hire wipes the previous trip; a coincident tick is discarded.
                r_unit_cnt <= '0;
                r_sec_cnt  <= '0;
                r_fare     <= '0;
                r_min      <= '0;
                r_sat      <= 1'b0;
            end else if (w_count) begin
                if (r_unit_cnt == UNIT_LAST) begin
                    r_unit_cnt <= '0;
                    if (!r_sat) begin
                        if (w_add[16]) begin
                            r_fare <= 16'h9999;
                            r_sat  <= 1'b1;
                        end else begin
                            r_fare <= w_add[15:0];
                        end
                    end
                end else begin
                    r_unit_cnt <= r_unit_cnt + 12'd1;
                end

                if (r_sec_cnt == SEC_LAST) begin
                    r_sec_cnt <= '0;
                    r_min     <= bcd_min_inc(r_min);
                end else begin
                    r_sec_cnt <= r_sec_cnt + 6'd1;
                end
            end
        end
    end

    assign wait_fare_bcd = r_fare;
    assign wait_min_bcd  = r_min;
    assign waiting       = r_waiting;
    assign wait_sat      = r_sat;

endmodule

// File: tb/tb_wait_fare.sv
// Directed bench for wait_fare: default-rate instance plus three short-unit instances
// that exercise BCD carries and saturation, all sharing trip/motion/reset inputs.
module tb_wait_fare;

    logic        clk;
    logic        rst;
    logic        trip_active;
    logic        moving;
    logic        tick_a, tick_b, tick_c, tick_d;
    logic [15:0] fare_a, fare_b, fare_c, fare_d;
    logic [7:0]  min_a, min_b, min_c, min_d;
    logic        waiting_a, waiting_b, waiting_c, waiting_d;
    logic        sat_a, sat_b, sat_c, sat_d;

    int n_tests = 0;
    int n_fail  = 0;

    wait_fare u_a (
        .clk(clk), .rst(rst), .trip_active(trip_active), .moving(moving), .tick_1s(tick_a),
        .wait_fare_bcd(fare_a), .wait_min_bcd(min_a), .waiting(waiting_a), .wait_sat(sat_a)
    );

    wait_fare #(.WAIT_UNIT_S(1), .WAIT_RATE_BCD(16'h0099)) u_b (
        .clk(clk), .rst(rst), .trip_active(trip_active), .moving(moving), .tick_1s(tick_b),
        .wait_fare_bcd(fare_b), .wait_min_bcd(min_b), .waiting(waiting_b), .wait_sat(sat_b)
    );

    wait_fare #(.WAIT_UNIT_S(1), .WAIT_RATE_BCD(16'h3333)) u_c (
        .clk(clk), .rst(rst), .trip_active(trip_active), .moving(moving), .tick_1s(tick_c),
        .wait_fare_bcd(fare_c), .wait_min_bcd(min_c), .waiting(waiting_c), .wait_sat(sat_c)
    );

    wait_fare #(.WAIT_UNIT_S(1), .WAIT_RATE_BCD(16'h5000)) u_d (
        .clk(clk), .rst(rst), .trip_active(trip_active), .moving(moving), .tick_1s(tick_d),
        .wait_fare_bcd(fare_d), .wait_min_bcd(min_d), .waiting(waiting_d), .wait_sat(sat_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One tick per cycle on the selected instance (0=a, 1=b, 2=c, 3=d).
    task automatic ticks(input int which, input int n);
        for (int i = 0; i < n; i++) begin
            case (which)
                0: tick_a = 1'b1;
                1: tick_b = 1'b1;
                2: tick_c = 1'b1;
                default: tick_d = 1'b1;
            endcase
            cyc();
            tick_a = 1'b0;
            tick_b = 1'b0;
            tick_c = 1'b0;
            tick_d = 1'b0;
        end
    endtask

    initial begin
        rst         = 1'b1;
        trip_active = 1'b1;
        moving      = 1'b0;
        tick_a      = 1'b0;
        tick_b      = 1'b0;
        tick_c      = 1'b0;
        tick_d      = 1'b0;

        // Reset held three cycles with ticks pulsing and trip active
        for (int i = 0; i < 3; i++) begin
            tick_a = ~tick_a;
            tick_b = tick_a;
            tick_c = tick_a;
            tick_d = tick_a;
            cyc();
        end
        check("rst_fare_a", fare_a, 16'h0000);
        check("rst_min_a", {8'h00, min_a}, 16'h0000);
        check("rst_waiting_a", {15'd0, waiting_a}, 16'h0000);
        check("rst_sat_a", {15'd0, sat_a}, 16'h0000);
        check("rst_fare_d", fare_d, 16'h0000);

        rst         = 1'b0;
        trip_active = 1'b0;
        tick_a      = 1'b0;
        tick_b      = 1'b0;
        tick_c      = 1'b0;
        tick_d      = 1'b0;
        cyc();
        check("post_rst_waiting", {15'd0, waiting_a}, 16'h0000);
        check("post_rst_fare", fare_a, 16'h0000);

        // Basic accumulation at default rate
        trip_active = 1'b1;
        moving      = 1'b0;
        cyc();
        check("start_waiting", {15'd0, waiting_a}, 16'h0001);
        ticks(0, 299);
        check("acc299_fare", fare_a, 16'h0000);
        check("acc299_min", {8'h00, min_a}, 16'h0004);
        ticks(0, 1);
        check("acc300_fare", fare_a, 16'h0010);
        check("acc300_min", {8'h00, min_a}, 16'h0005);
        ticks(0, 600);
        check("acc900_fare", fare_a, 16'h0030);
        check("acc900_min", {8'h00, min_a}, 16'h0015);

        // BCD carry chain
        ticks(1, 1);
        check("carry_1", fare_b, 16'h0099);
        ticks(1, 1);
        check("carry_2", fare_b, 16'h0198);
        ticks(1, 1);
        check("carry_3", fare_b, 16'h0297);

        // Exact 9999 without carry, then carry-out saturates
        ticks(2, 2);
        check("c_6666", fare_c, 16'h6666);
        ticks(2, 1);
        check("c_9999", fare_c, 16'h9999);
        check("c_9999_sat", {15'd0, sat_c}, 16'h0000);
        ticks(2, 1);
        check("c_ovf", fare_c, 16'h9999);
        check("c_ovf_sat", {15'd0, sat_c}, 16'h0001);

        // Saturation at rate 5000
        ticks(3, 1);
        check("d_5000", fare_d, 16'h5000);
        check("d_5000_sat", {15'd0, sat_d}, 16'h0000);
        ticks(3, 1);
        check("d_sat", fare_d, 16'h9999);
        check("d_sat_flag", {15'd0, sat_d}, 16'h0001);
        ticks(3, 3);
        check("d_hold", fare_d, 16'h9999);
        check("d_hold_flag", {15'd0, sat_d}, 16'h0001);

        // Trip end: values hold, ticks ignored in IDLE
        trip_active = 1'b0;
        cyc();
        check("end_waiting", {15'd0, waiting_a}, 16'h0000);
        check("end_fare_a", fare_a, 16'h0030);
        check("end_min_a", {8'h00, min_a}, 16'h0015);
        check("end_sat_d", {15'd0, sat_d}, 16'h0001);
        ticks(0, 5);
        check("idle_fare_a", fare_a, 16'h0030);
        check("idle_min_a", {8'h00, min_a}, 16'h0015);

        // Restart with a coincident tick: clear wins
        trip_active = 1'b1;
        tick_a      = 1'b1;
        tick_d      = 1'b1;
        cyc();
        tick_a = 1'b0;
        tick_d = 1'b0;
        check("restart_fare_a", fare_a, 16'h0000);
        check("restart_min_a", {8'h00, min_a}, 16'h0000);
        check("restart_fare_d", fare_d, 16'h0000);
        check("restart_sat_d", {15'd0, sat_d}, 16'h0000);
        check("restart_waiting", {15'd0, waiting_a}, 16'h0001);

        // Motion interruption: partial counts persist
        ticks(0, 200);
        check("mi200_fare", fare_a, 16'h0000);
        check("mi200_min", {8'h00, min_a}, 16'h0003);
        moving = 1'b1;
        cyc();
        check("mi_waiting_drop", {15'd0, waiting_a}, 16'h0000);
        ticks(0, 500);
        check("mi_move_fare", fare_a, 16'h0000);
        check("mi_move_min", {8'h00, min_a}, 16'h0003);
        moving = 1'b0;
        cyc();
        check("mi_waiting_rise", {15'd0, waiting_a}, 16'h0001);
        ticks(0, 99);
        check("mi99_fare", fare_a, 16'h0000);
        check("mi99_min", {8'h00, min_a}, 16'h0004);
        ticks(0, 1);
        check("mi100_fare", fare_a, 16'h0010);
        check("mi100_min", {8'h00, min_a}, 16'h0005);

        // Mid-operation reset with a pending tick
        rst    = 1'b1;
        tick_a = 1'b1;
        cyc();
        rst    = 1'b0;
        tick_a = 1'b0;
        check("midrst_fare", fare_a, 16'h0000);
        check("midrst_min", {8'h00, min_a}, 16'h0000);
        check("midrst_waiting", {15'd0, waiting_a}, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
